gol_run_ctrl: RTL and testbench

Sequencing controller for the 7x7 Game of Life datapath. It turns raw push-buttons into the datapath's 2-bit `state` code, its `stop` clear pulse and per-cell program writes. In RUN it issues generation ticks at a programmable rate, counts generations, and halts automatically when the grid dies out or stops changing. It sits between the board buttons and the datapath and observes the datapath's 49-bit `grid` output.

---
 rtl/gol_run_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_gol_run_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gol_run_ctrl.sv
// Button sequencer, generation ticker and halt detector for the 7x7 Life grid.
// Define GOL_CTRL_DEBOUNCE_EN to add a per-button stability filter.
module gol_run_ctrl #(
  parameter int TICK_DIV     = 1000000,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic        clka,
  input  logic        rst_n,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic        btn_clear,
  input  logic        btn0,
  input  logic        btn1,
  input  logic [48:0] grid,
  output logic [1:0]  state,
  output logic        stop,
  output logic        cell_we,
  output logic        cell_val,
  output logic [5:0]  cell_idx,
  output logic        gen_tick,
  output logic [15:0] gen_count,
  output logic        extinct,
  output logic        stable
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PROG  = 2'b01,
    RUN   = 2'b10,
    PAUSE = 2'b11
  } st_e;

  logic [4:0] raw, s1_q, s2_q, lvl, prev_q, arm_q, edg;
  logic [1:0] prime_q;

  assign raw = {btn_clear, btn_pause, btn_start, btn1, btn0};

  // Edges stay disarmed until a real low level is seen after reset,
  // so a button held through reset never fires.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
      arm_q   <= '0;
      prime_q <= '0;
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      prev_q <= lvl;
      if (!prime_q[1]) prime_q <= prime_q + 2'd1;
      else             arm_q   <= arm_q | ~s2_q;
    end
  end

`ifdef GOL_CTRL_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  logic [4:0]    flt_q;
  logic [DW-1:0] dcnt_q [5];

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      flt_q <= '0;
      for (int i = 0; i < 5; i++) dcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (s2_q[i] == flt_q[i]) begin
          dcnt_q[i] <= '0;
        end else if (dcnt_q[i] == DW'(DEBOUNCE_CYC - 1)) begin
          flt_q[i]  <= s2_q[i];
          dcnt_q[i] <= '0;
        end else begin
          dcnt_q[i] <= dcnt_q[i] + DW'(1);
        end
      end
    end
  end

  assign lvl = flt_q;
`else
  logic unused_dbc;
  assign unused_dbc = ^DEBOUNCE_CYC;
  assign lvl = s2_q;
`endif

  assign edg = lvl & ~prev_q & arm_q;

  logic e_clr, e_pau, e_sta, e_wr;
  assign e_clr = edg[4];
  assign e_pau = edg[3] & ~edg[4];
  assign e_sta = edg[2] & ~|edg[4:3];
  assign e_wr  = (edg[1] ^ edg[0]) & ~|edg[4:2];

  st_e         state_q, state_d;
  logic        stop_q, stop_d;
  logic        cell_we_q, we_d;
  logic        cell_val_q, val_d;
  logic [5:0]  cell_idx_q, idx_d, tgt;
  logic        gen_tick_q, tick_d;
  logic [15:0] gen_count_q, cnt_d;
  logic        extinct_q, ext_d;
  logic        stable_q, stb_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [48:0] snap_q, snap_d;
  logic        snapv_q, snapv_d;
  logic        wrap, dead, same, do_tick, run_in;

  // The index advances the cycle after its strobe, so the strobe
  // always carries the index it writes.
  assign tgt  = !cell_we_q             ? cell_idx_q :
                (cell_idx_q == 6'd48)  ? 6'd0 :
                                         cell_idx_q + 6'd1;
  assign wrap = (pre_q == PMAX);
  assign dead = (grid == '0);
  assign same = snapv_q && (grid == snap_q);

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stop_q      <= 1'b0;
      cell_we_q   <= 1'b0;
      cell_val_q  <= 1'b0;
      cell_idx_q  <= '0;
      gen_tick_q  <= 1'b0;
      gen_count_q <= '0;
      extinct_q   <= 1'b0;
      stable_q    <= 1'b0;
      pre_q       <= '0;
      snap_q      <= '0;
      snapv_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_q      <= stop_d;
      cell_we_q   <= we_d;
      cell_val_q  <= val_d;
      cell_idx_q  <= idx_d;
      gen_tick_q  <= tick_d;
      gen_count_q <= cnt_d;
      extinct_q   <= ext_d;
      stable_q    <= stb_d;
      pre_q       <= pre_d;
      snap_q      <= snap_d;
      snapv_q     <= snapv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (e_clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (e_sta) state_d = PROG;
        PROG:  if (e_sta || (e_wr && tgt == 6'd48))
                 state_d = RUN;
        RUN:   if (e_pau || (wrap && (dead || same)))
                 state_d = PAUSE;
        PAUSE: if (e_pau) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    stop_d  = 1'b0;
    we_d    = 1'b0;
    val_d   = cell_val_q;
    idx_d   = tgt;
    tick_d  = 1'b0;
    cnt_d   = gen_count_q;
    pre_d   = pre_q;
    ext_d   = extinct_q;
    stb_d   = stable_q;
    snap_d  = snap_q;
    snapv_d = snapv_q;
    do_tick = 1'b0;
    run_in  = 1'b0;
    if (e_clr) begin
      stop_d  = 1'b1;
      idx_d   = '0;
      cnt_d   = '0;
      pre_d   = '0;
      ext_d   = 1'b0;
      stb_d   = 1'b0;
      snapv_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (e_sta) idx_d = '0;
        PROG: begin
          if (e_wr) begin
            we_d  = 1'b1;
            val_d = edg[1];
          end
          run_in = e_sta || (e_wr && tgt == 6'd48);
        end
        RUN: if (!e_pau) begin
          if (!wrap) begin
            pre_d = pre_q + PW'(1);
          end else begin
            pre_d = '0;
            if (dead)      ext_d   = 1'b1;
            else if (same) stb_d   = 1'b1;
            else           do_tick = 1'b1;
          end
        end
        PAUSE: begin
          if (e_pau)      pre_d   = '0;
          else if (e_sta) do_tick = 1'b1;
        end
        default: ;
      endcase
      if (run_in) begin
        pre_d   = '0;
        ext_d   = 1'b0;
        stb_d   = 1'b0;
        snapv_d = 1'b0;
      end
      if (do_tick) begin
        tick_d  = 1'b1;
        cnt_d   = (gen_count_q == 16'hFFFF) ? gen_count_q
                                            : gen_count_q + 16'd1;
        snap_d  = grid;
        snapv_d = 1'b1;
      end
    end
  end

  assign state     = state_q;
  assign stop      = stop_q;
  assign cell_we   = cell_we_q;
  assign cell_val  = cell_val_q;
  assign cell_idx  = cell_idx_q;
  assign gen_tick  = gen_tick_q;
  assign gen_count = gen_count_q;
  assign extinct   = extinct_q;
  assign stable    = stable_q;

endmodule

// File: tb/tb_gol_run_ctrl.sv
// Directed bench for gol_run_ctrl with a behavioural 7x7 Life datapath.
// Runs with TICK_DIV=4 and no debounce filter.
module tb_gol_run_ctrl;

  localparam logic [4:0] CLR = 5'b10000;
  localparam logic [4:0] PAU = 5'b01000;
  localparam logic [4:0] STA = 5'b00100;
  localparam logic [4:0] B1  = 5'b00010;
  localparam logic [4:0] B0  = 5'b00001;

  logic        clka = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  b = '0;
  logic [48:0] grid = '0;
  logic [1:0]  state;
  logic        stop, cell_we, cell_val, gen_tick, extinct, stable;
  logic [5:0]  cell_idx;
  logic [15:0] gen_count;

  int n_chk = 0;
  int n_err = 0;

  gol_run_ctrl #(.TICK_DIV(4), .DEBOUNCE_CYC(16)) dut (
    .clka(clka), .rst_n(rst_n),
    .btn_start(b[2]), .btn_pause(b[3]), .btn_clear(b[4]),
    .btn0(b[0]), .btn1(b[1]),
    .grid(grid), .state(state), .stop(stop),
    .cell_we(cell_we), .cell_val(cell_val), .cell_idx(cell_idx),
    .gen_tick(gen_tick), .gen_count(gen_count),
    .extinct(extinct), .stable(stable)
  );

  always #5 clka = ~clka;

  function automatic logic [48:0] life(input logic [48:0] g);
    logic [48:0] n;
    int k;
    n = '0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) begin
        k = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 7 &&
                c + dc >= 0 && c + dc < 7)
              k += int'(g[(r + dr) * 7 + c + dc]);
        n[r * 7 + c] = (k == 3) || (g[r * 7 + c] && k == 2);
      end
    return n;
  endfunction

  always @(posedge clka) begin
    if (stop)          grid <= '0;
    else if (cell_we)  grid[cell_idx] <= cell_val;
    else if (gen_tick) grid <= life(grid);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [4:0] m);
    b = m;
    @(negedge clka);
    @(negedge clka);
    b = '0;
    @(negedge clka);
  endtask

  task automatic load_grid(input logic [48:0] pat);
    press(CLR);
    press(STA);
    for (int i = 0; i < 49; i++) press(pat[i] ? B1 : B0);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_stop"},  32'(stop), 32'd0);
    check({tag, "_we"},    32'(cell_we), 32'd0);
    check({tag, "_val"},   32'(cell_val), 32'd0);
    check({tag, "_idx"},   32'(cell_idx), 32'd0);
    check({tag, "_tick"},  32'(gen_tick), 32'd0);
    check({tag, "_cnt"},   32'(gen_count), 32'd0);
    check({tag, "_ext"},   32'(extinct), 32'd0);
    check({tag, "_stb"},   32'(stable), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clka);
    chk_reset("rst");
    rst_n = 1'b1;
    repeat (4) @(negedge clka);

    // full programming with alternating values
    press(STA);
    check("prog_state", 32'(state), 32'd1);
    check("prog_idx0", 32'(cell_idx), 32'd0);
    for (int i = 0; i < 49; i++) begin
      press((i % 2 == 0) ? B1 : B0);
      check($sformatf("prog_we%0d", i), 32'(cell_we), 32'd1);
      check($sformatf("prog_val%0d", i), 32'(cell_val),
            32'((i % 2 == 0) ? 1 : 0));
      check($sformatf("prog_idx%0d", i), 32'(cell_idx), 32'(i));
      if (i < 48) check($sformatf("prog_st%0d", i), 32'(state), 32'd1);
    end
    check("prog_run", 32'(state), 32'd2);
    @(negedge clka);
    check("prog_we_off", 32'(cell_we), 32'd0);
    check("prog_idx_wrap", 32'(cell_idx), 32'd0);
    press(CLR);
    check("clr_stop", 32'(stop), 32'd1);
    check("clr_state", 32'(state), 32'd0);
    check("clr_cnt", 32'(gen_count), 32'd0);
    @(negedge clka);
    check("clr_stop_off", 32'(stop), 32'd0);

    // blinker: tick every 4 cycles, never stable
    load_grid(49'h7 << 23);
    check("blk_run", 32'(state), 32'd2);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clka);
      check($sformatf("blk_tick%0d", c), 32'(gen_tick),
            32'((c % 4 == 0) ? 1 : 0));
    end
    check("blk_cnt3", 32'(gen_count), 32'd3);
    check("blk_stb", 32'(stable), 32'd0);
    check("blk_state", 32'(state), 32'd2);
    repeat (8) @(negedge clka);
    check("blk_cnt5", 32'(gen_count), 32'd5);

    // reset mid-run, start held through release
    b = STA;
    rst_n = 1'b0;
    #1;
    chk_reset("mid");
    repeat (2) @(negedge clka);
    rst_n = 1'b1;
    repeat (6) @(negedge clka);
    check("held_state", 32'(state), 32'd0);
    b = '0;
    repeat (4) @(negedge clka);
    check("held_state2", 32'(state), 32'd0);

    // 2x2 block: one tick, then stable
    load_grid((49'h3 << 8) | (49'h3 << 15));
    for (int c = 1; c <= 8; c++) begin
      @(negedge clka);
      check($sformatf("still_tick%0d", c), 32'(gen_tick),
            32'((c == 4) ? 1 : 0));
    end
    check("still_stb", 32'(stable), 32'd1);
    check("still_state", 32'(state), 32'd3);
    check("still_cnt", 32'(gen_count), 32'd1);
    check("still_ext", 32'(extinct), 32'd0);

    // single cell: dies, extinct, then single-step
    load_grid(49'h1 << 24);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clka);
      check($sformatf("ext_tick%0d", c), 32'(gen_tick),
            32'((c == 4) ? 1 : 0));
    end
    check("ext_flag", 32'(extinct), 32'd1);
    check("ext_state", 32'(state), 32'd3);
    check("ext_cnt", 32'(gen_count), 32'd1);
    check("ext_stb", 32'(stable), 32'd0);
    press(STA);
    check("step_tick", 32'(gen_tick), 32'd1);
    check("step_cnt", 32'(gen_count), 32'd2);
    check("step_state", 32'(state), 32'd3);
    @(negedge clka);
    check("step_tick_off", 32'(gen_tick), 32'd0);
    press(PAU);
    check("resume_state", 32'(state), 32'd2);
    repeat (3) @(negedge clka);
    check("resume_st3", 32'(state), 32'd2);
    @(negedge clka);
    check("resume_st4", 32'(state), 32'd3);
    check("resume_cnt", 32'(gen_count), 32'd2);
    check("resume_ext", 32'(extinct), 32'd1);

    // clear beats pause in the same cycle
    press(PAU);
    check("sim_run", 32'(state), 32'd2);
    press(CLR | PAU);
    check("sim_stop", 32'(stop), 32'd1);
    check("sim_state", 32'(state), 32'd0);
    check("sim_ext", 32'(extinct), 32'd0);
    @(negedge clka);
    check("sim_stop_off", 32'(stop), 32'd0);

    // btn0+btn1 together are dropped in PROGRAM
    press(B1);
    check("idle_b1", 32'(state), 32'd0);
    press(STA);
    check("both_prog", 32'(state), 32'd1);
    press(B0 | B1);
    check("both_we", 32'(cell_we), 32'd0);
    check("both_idx", 32'(cell_idx), 32'd0);
    press(B1);
    check("one_we", 32'(cell_we), 32'd1);
    check("one_val", 32'(cell_val), 32'd1);
    check("one_idx", 32'(cell_idx), 32'd0);
    @(negedge clka);
    check("one_idx_inc", 32'(cell_idx), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
